// File: rtl/op_issue_pkg.sv
// op_issue_pkg: opcode map, instruction field positions, FSM states
// and the opcode classifier shared by the issue controller and fetch.
package op_issue_pkg;

   localparam int OPC_LSB = 15;
   localparam int RA_LSB  = 11;
   localparam int RB_LSB  = 7;

   localparam logic [4:0] OP_TRAP  = 5'd0;
   localparam logic [4:0] OP_NOP   = 5'd1;
   localparam logic [4:0] OP_JMP   = 5'd2;
   localparam logic [4:0] OP_NOT   = 5'd8;
   localparam logic [4:0] OP_AND   = 5'd9;
   localparam logic [4:0] OP_OR    = 5'd10;
   localparam logic [4:0] OP_XOR   = 5'd11;
   localparam logic [4:0] OP_SHFTR = 5'd12;
   localparam logic [4:0] OP_SHFTL = 5'd13;
   localparam logic [4:0] OP_ROTR  = 5'd14;
   localparam logic [4:0] OP_ROTL  = 5'd15;
   localparam logic [4:0] OP_SWAP  = 5'd16;
   localparam logic [4:0] OP_INC   = 5'd17;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WB1,
      S_WB2,
      S_HALT
   } state_t;

   typedef struct packed {
      logic alu;
      logic nowrite;
      logic swap;
      logic trap;
      logic illegal;
      logic forceb0;
   } op_class_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      op_class_t c;
      c         = '0;
      c.trap    = (op == OP_TRAP);
      c.swap    = (op == OP_SWAP);
      c.alu     = ((op >= OP_NOT) && (op <= OP_ROTL)) || (op == OP_INC);
      c.illegal = ((op >= 5'd3) && (op <= 5'd7)) || (op >= 5'd18);
      c.nowrite = (op == OP_NOP) || (op == OP_JMP) || c.illegal;
      c.forceb0 = (op == OP_NOT) || (op == OP_INC) ||
                  (op == OP_TRAP) || (op == OP_NOP);
      return c;
   endfunction

endpackage

// File: rtl/op_field_decode.sv
// op_field_decode: splits an instruction word into opcode, register
// fields and class bits.
module op_field_decode
   import op_issue_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int OP_W   = 5,
   parameter int REG_AW = 4
) (
   input  logic [DATA_W-1:0] i_instr,
   output logic [OP_W-1:0]   o_opcode,
   output logic [REG_AW-1:0] o_ra,
   output logic [REG_AW-1:0] o_rb,
   output op_class_t         o_cls
);

   logic w_unused_low;

   assign o_opcode     = i_instr[OPC_LSB +: OP_W];
   assign o_ra         = i_instr[RA_LSB +: REG_AW];
   assign o_rb         = i_instr[RB_LSB +: REG_AW];
   assign o_cls        = op_class(o_opcode);
   assign w_unused_low = ^i_instr[RB_LSB-1:0];

endmodule

// File: rtl/op_issue_ctrl.sv
// op_issue_ctrl: single-issue sequencer that reads operands, drives the
// op path bank, captures the result and writes it back.
module op_issue_ctrl
   import op_issue_pkg::*;
#(
   parameter int DATA_W   = 20,
   parameter int OP_W     = 5,
   parameter int REG_AW   = 4,
   parameter int EXEC_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_instr,
   output logic              in_ready,
   output logic [REG_AW-1:0] rf_raddr_a,
   output logic [REG_AW-1:0] rf_raddr_b,
   input  logic [DATA_W-1:0] rf_rdata_a,
   input  logic [DATA_W-1:0] rf_rdata_b,
   output logic [OP_W-1:0]   op_sel,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   input  logic [DATA_W-1:0] op_w,
   input  logic              op_carry,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              pc_load,
   output logic [DATA_W-1:0] pc_target,
   output logic              done,
   output logic              illegal,
   output logic              carry_flag,
   output logic              halted
);

   localparam logic [1:0] CNT_INIT = 2'(EXEC_LAT - 1);

   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_instr;
   logic [DATA_W-1:0] r_opa;
   logic [DATA_W-1:0] r_opb;
   logic [DATA_W-1:0] r_res;
   logic [1:0]        r_cnt;
   logic              r_carry;
   logic [OP_W-1:0]   w_opc;
   logic [REG_AW-1:0] w_ra;
   logic [REG_AW-1:0] w_rb;
   op_class_t         w_cls;

   op_field_decode #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W),
      .REG_AW (REG_AW)
   ) u_dec (
      .i_instr  (r_instr),
      .o_opcode (w_opc),
      .o_ra     (w_ra),
      .o_rb     (w_rb),
      .o_cls    (w_cls)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_instr <= '0;
         r_opa   <= '0;
         r_opb   <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (in_valid) r_instr <= in_instr;
            S_READ: begin
               r_opa <= rf_rdata_a;
               r_opb <= w_cls.forceb0 ? '0 : rf_rdata_b;
               r_cnt <= CNT_INIT;
            end
            S_EXEC: begin
               if (w_cls.alu) begin
                  if (r_cnt == 2'd0) begin
                     r_res <= op_w;
                     if (w_opc == OP_INC) r_carry <= op_carry;
                  end else begin
                     r_cnt <= r_cnt - 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      rf_we     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      pc_load   = 1'b0;
      pc_target = '0;
      done      = 1'b0;
      illegal   = 1'b0;
      halted    = 1'b0;
      unique case (r_state)
         S_IDLE: if (in_valid) w_next = S_READ;
         S_READ: w_next = S_EXEC;
         S_EXEC: begin
            if (w_cls.trap) begin
               done   = 1'b1;
               halted = 1'b1;
               w_next = S_HALT;
            end else if (w_cls.nowrite) begin
               done    = 1'b1;
               illegal = w_cls.illegal;
               if (w_opc == OP_JMP) begin
                  pc_load   = 1'b1;
                  pc_target = r_opa;
               end
               w_next = S_IDLE;
            end else if (w_cls.swap || (r_cnt == 2'd0)) begin
               w_next = S_WB1;
            end
         end
         S_WB1: begin
            rf_we    = 1'b1;
            rf_waddr = w_ra;
            rf_wdata = w_cls.swap ? r_opb : r_res;
            done     = !w_cls.swap;
            w_next   = w_cls.swap ? S_WB2 : S_IDLE;
         end
         S_WB2: begin
            rf_we    = 1'b1;
            rf_waddr = w_rb;
            rf_wdata = r_opa;
            done     = 1'b1;
            w_next   = S_IDLE;
         end
         S_HALT: halted = 1'b1;
         default: w_next = S_IDLE;
      endcase
   end

   // reset holds the FSM in IDLE, so qualify ready with rst_n
   assign in_ready   = rst_n && (r_state == S_IDLE);
   assign rf_raddr_a = w_ra;
   assign rf_raddr_b = w_rb;
   assign op_sel     = w_opc;
   assign op_a       = r_opa;
   assign op_b       = r_opb;
   assign carry_flag = r_carry;

endmodule

// File: tb/tb_op_issue_ctrl.sv
// tb_op_issue_ctrl: directed vectors and hand-written sequences for
// op_issue_ctrl with EXEC_LAT=1 and EXEC_LAT=3 instances.
module tb_op_issue_ctrl;
   import op_issue_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, rf_we, pc_load, done, illegal;
   logic        carry_flag, halted, op_carry;
   logic [19:0] in_instr, rf_rdata_a, rf_rdata_b, op_a, op_b, op_w;
   logic [19:0] rf_wdata, pc_target;
   logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
   logic [4:0]  op_sel;

   logic        in_valid3, in_ready3, rf_we3, pc_load3, done3, illegal3;
   logic        carry3, halted3;
   logic [19:0] in_instr3, rdata_a3, rdata_b3, op_a3, op_b3, op_w3;
   logic [19:0] wdata3, pc_target3;
   logic [3:0]  raddr_a3, raddr_b3, waddr3;
   logic [4:0]  op_sel3;

   logic [19:0] rf [16];
   logic [15:0] cyc = '0;
   int          n_checks = 0;
   int          n_errors = 0;

   always @(posedge clk) cyc <= cyc + 16'd1;

   function automatic logic [19:0] opfn(input logic [4:0] op,
                                        input logic [19:0] a,
                                        input logic [19:0] b);
      case (op)
         OP_NOT:   return ~a;
         OP_AND:   return a & b;
         OP_OR:    return a | b;
         OP_XOR:   return a ^ b;
         OP_SHFTR: return a >> 1;
         OP_SHFTL: return a << 1;
         OP_ROTR:  return {a[0], a[19:1]};
         OP_ROTL:  return {a[18:0], a[19]};
         OP_INC:   return a + 20'd1;
         default:  return 20'h0BAD0;
      endcase
   endfunction

   assign rf_rdata_a = rf[rf_raddr_a];
   assign rf_rdata_b = rf[rf_raddr_b];
   assign op_w       = opfn(op_sel, op_a, op_b);
   assign op_carry   = (op_sel == OP_INC) && (op_a == 20'hFFFFF);
   assign rdata_a3   = rf[raddr_a3];
   assign rdata_b3   = rf[raddr_b3];
   assign op_w3      = {4'hA, cyc};

   op_issue_ctrl #(.EXEC_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
      .in_ready(in_ready), .rf_raddr_a(rf_raddr_a),
      .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a),
      .rf_rdata_b(rf_rdata_b), .op_sel(op_sel), .op_a(op_a), .op_b(op_b),
      .op_w(op_w), .op_carry(op_carry), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_load(pc_load),
      .pc_target(pc_target), .done(done), .illegal(illegal),
      .carry_flag(carry_flag), .halted(halted)
   );

   op_issue_ctrl #(.EXEC_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid3),
      .in_instr(in_instr3), .in_ready(in_ready3), .rf_raddr_a(raddr_a3),
      .rf_raddr_b(raddr_b3), .rf_rdata_a(rdata_a3),
      .rf_rdata_b(rdata_b3), .op_sel(op_sel3), .op_a(op_a3),
      .op_b(op_b3), .op_w(op_w3), .op_carry(1'b0), .rf_we(rf_we3),
      .rf_waddr(waddr3), .rf_wdata(wdata3), .pc_load(pc_load3),
      .pc_target(pc_target3), .done(done3), .illegal(illegal3),
      .carry_flag(carry3), .halted(halted3)
   );

   typedef struct {
      logic [4:0]  op;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [19:0] va;
      logic [19:0] vb;
      logic [19:0] wd;
      int          we_at;
      int          done_at;
      bit          ill;
      int          pcl_at;
      logic [19:0] pct;
      logic [19:0] opb;
      bit          c;
   } vec_t;

   vec_t vecs [11];

   int          o_we_at, o_we_cnt, o_done_at, o_done_cnt;
   int          o_ill_at, o_pcl_at, o_halt_at, o_rdy_at;
   logic [3:0]  o_wa;
   logic [19:0] o_wd, o_pct, o_opb;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // offer one instruction at cycle N; k counts cycles after N
   task automatic issue(input logic [4:0] op, input logic [3:0] ra,
                        input logic [3:0] rb);
      @(posedge clk); #1;
      chk("ready_before_issue", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_instr = {op, ra, rb, 7'h55};
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_instr = '0;
      o_we_at = 0; o_we_cnt = 0; o_done_at = 0; o_done_cnt = 0;
      o_ill_at = 0; o_pcl_at = 0; o_halt_at = 0; o_rdy_at = 0;
      o_wa = '0; o_wd = '0; o_pct = '0; o_opb = '0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) begin
            @(posedge clk); #1;
         end
         if (rf_we) begin
            if (o_we_cnt == 0) begin
               o_we_at = k; o_wa = rf_waddr; o_wd = rf_wdata;
            end
            o_we_cnt++;
            rf[rf_waddr] = rf_wdata;
         end
         if (done) begin
            if (o_done_cnt == 0) o_done_at = k;
            o_done_cnt++;
         end
         if (illegal && o_ill_at == 0) o_ill_at = k;
         if (pc_load && o_pcl_at == 0) begin
            o_pcl_at = k; o_pct = pc_target;
         end
         if (halted && o_halt_at == 0) o_halt_at = k;
         if (in_ready && o_rdy_at == 0) o_rdy_at = k;
         if (k == 2) o_opb = op_b;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] c0;
      int          w3_at;
      logic [19:0] w3_d;
      int          d3_at;

      in_valid = 0; in_instr = '0; in_valid3 = 0; in_instr3 = '0;
      for (int r = 0; r < 16; r++) rf[r] = '0;

      vecs[0]  = '{OP_AND,  1, 2, 20'h0F0F0, 20'h0FF00, 20'h0F000,
                   3, 3, 0, 0, 20'h0, 20'h0FF00, 0};
      vecs[1]  = '{OP_OR,   1, 2, 20'h0F0F0, 20'h0FF00, 20'h0FFF0,
                   3, 3, 0, 0, 20'h0, 20'h0FF00, 0};
      vecs[2]  = '{OP_XOR,  1, 2, 20'h0F0F0, 20'h0FF00, 20'h00FF0,
                   3, 3, 0, 0, 20'h0, 20'h0FF00, 0};
      vecs[3]  = '{OP_NOT,  7, 2, 20'h0000F, 20'h0FF00, 20'hFFFF0,
                   3, 3, 0, 0, 20'h0, 20'h00000, 0};
      vecs[4]  = '{OP_SHFTL, 8, 9, 20'h80001, 20'h00004, 20'h00002,
                   3, 3, 0, 0, 20'h0, 20'h00004, 0};
      vecs[5]  = '{OP_ROTR, 8, 9, 20'h00003, 20'h00004, 20'h80001,
                   3, 3, 0, 0, 20'h0, 20'h00004, 0};
      vecs[6]  = '{OP_INC,  3, 4, 20'hFFFFF, 20'h0AAAA, 20'h00000,
                   3, 3, 0, 0, 20'h0, 20'h00000, 1};
      vecs[7]  = '{OP_JMP,  6, 5, 20'h00040, 20'h00777, 20'h0,
                   0, 2, 0, 2, 20'h00040, 20'h00777, 1};
      vecs[8]  = '{5'd5,    1, 2, 20'h11111, 20'h00001, 20'h0,
                   0, 2, 1, 0, 20'h0, 20'h00001, 1};
      vecs[9]  = '{OP_NOP,  1, 2, 20'h11111, 20'h12345, 20'h0,
                   0, 2, 0, 0, 20'h0, 20'h00000, 1};
      vecs[10] = '{OP_INC, 10, 11, 20'h00001, 20'h00005, 20'h00002,
                   3, 3, 0, 0, 20'h0, 20'h00000, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_strobes", {28'd0, rf_we, done, illegal, pc_load}, 32'd0);
      chk("rst_flags", {30'd0, halted, carry_flag}, 32'd0);
      chk("rst_op_a", {12'd0, op_a}, 32'd0);
      chk("rst_op_sel", {27'd0, op_sel}, 32'd0);
      chk("rst_pc_target", {12'd0, pc_target}, 32'd0);
      chk("rst_in_ready3", {31'd0, in_ready3}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 11; i++) begin
         rf[vecs[i].ra] = vecs[i].va;
         rf[vecs[i].rb] = vecs[i].vb;
         issue(vecs[i].op, vecs[i].ra, vecs[i].rb);
         chk($sformatf("v%0d_we_at", i), o_we_at, vecs[i].we_at);
         chk($sformatf("v%0d_we_cnt", i), o_we_cnt,
             (vecs[i].we_at != 0) ? 1 : 0);
         if (vecs[i].we_at != 0) begin
            chk($sformatf("v%0d_waddr", i), {28'd0, o_wa},
                {28'd0, vecs[i].ra});
            chk($sformatf("v%0d_wdata", i), {12'd0, o_wd},
                {12'd0, vecs[i].wd});
         end
         chk($sformatf("v%0d_done_at", i), o_done_at, vecs[i].done_at);
         chk($sformatf("v%0d_done_cnt", i), o_done_cnt, 1);
         chk($sformatf("v%0d_ill_at", i), o_ill_at,
             vecs[i].ill ? vecs[i].done_at : 0);
         chk($sformatf("v%0d_pcl_at", i), o_pcl_at, vecs[i].pcl_at);
         if (vecs[i].pcl_at != 0)
            chk($sformatf("v%0d_pc_target", i), {12'd0, o_pct},
                {12'd0, vecs[i].pct});
         chk($sformatf("v%0d_op_b", i), {12'd0, o_opb},
             {12'd0, vecs[i].opb});
         chk($sformatf("v%0d_carry", i), {31'd0, carry_flag},
             {31'd0, vecs[i].c});
         chk($sformatf("v%0d_rdy_at", i), o_rdy_at,
             vecs[i].done_at + 1);
         chk($sformatf("v%0d_halt_at", i), o_halt_at, 0);
      end

      rf[4] = 20'h12345;
      rf[5] = 20'hABCDE;
      issue(OP_SWAP, 4, 5);
      chk("swap_we_at", o_we_at, 3);
      chk("swap_wb1_addr", {28'd0, o_wa}, 32'd4);
      chk("swap_wb1_data", {12'd0, o_wd}, 32'h000ABCDE);
      chk("swap_we_cnt", o_we_cnt, 2);
      chk("swap_done_cnt", o_done_cnt, 1);
      chk("swap_done_at", o_done_at, 4);
      chk("swap_r4", {12'd0, rf[4]}, 32'h000ABCDE);
      chk("swap_r5", {12'd0, rf[5]}, 32'h00012345);
      chk("swap_rdy_at", o_rdy_at, 5);

      rf[6] = 20'h00111;
      issue(OP_SWAP, 6, 6);
      chk("swap_same_cnt", o_we_cnt, 2);
      chk("swap_same_r6", {12'd0, rf[6]}, 32'h00000111);

      issue(OP_TRAP, 0, 0);
      chk("trap_halt_at", o_halt_at, 2);
      chk("trap_done_at", o_done_at, 2);
      chk("trap_done_cnt", o_done_cnt, 1);
      chk("trap_we_cnt", o_we_cnt, 0);
      chk("trap_rdy_at", o_rdy_at, 0);
      in_valid = 1'b1;
      in_instr = {OP_AND, 4'd1, 4'd2, 7'h0};
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("halt_hold", {29'd0, in_ready, halted, done}, 32'b010);
      end
      in_valid = 1'b0;
      in_instr = '0;

      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      chk("unhalt", {30'd0, halted, in_ready}, 32'b01);

      rf[1] = 20'h0F0F0;
      rf[2] = 20'h0FF00;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_instr = {OP_AND, 4'd1, 4'd2, 7'h0};
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_instr = '0;
      @(posedge clk); #1;
      chk("midexec_op_a", {12'd0, op_a}, 32'h0000F0F0);
      rst_n = 1'b0;
      #1;
      chk("midrst_strobes", {29'd0, rf_we, done, in_ready}, 32'd0);
      chk("midrst_ops", {op_sel, op_a[13:0], op_b[12:0]}, 32'd0);
      @(posedge clk); #1;
      chk("midrst_no_we", {31'd0, rf_we}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("midrst_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("midrst_idle_we", {30'd0, rf_we, done}, 32'd0);

      @(posedge clk); #1;
      chk("lat3_ready", {31'd0, in_ready3}, 32'd1);
      in_valid3 = 1'b1;
      in_instr3 = {OP_XOR, 4'd1, 4'd2, 7'h2A};
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      in_instr3 = '0;
      c0 = cyc;
      w3_at = 0; w3_d = '0; d3_at = 0;
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) begin
            @(posedge clk); #1;
         end
         if (rf_we3 && w3_at == 0) begin
            w3_at = k; w3_d = wdata3;
            rf[waddr3] = wdata3;
         end
         if (done3 && d3_at == 0) d3_at = k;
         if (k == 4) begin
            chk("lat3_op_a", {12'd0, op_a3}, 32'h0000F0F0);
            chk("lat3_op_b", {12'd0, op_b3}, 32'h0000FF00);
            chk("lat3_op_sel", {27'd0, op_sel3}, {27'd0, OP_XOR});
         end
      end
      chk("lat3_we_at", w3_at, 5);
      chk("lat3_wdata", {12'd0, w3_d}, {12'd0, 4'hA, c0 + 16'd3});
      chk("lat3_done_at", d3_at, 5);
      chk("lat3_misc", {27'd0, pc_load3, illegal3, halted3, carry3,
                        |pc_target3}, 32'd0);
      chk("lat3_ready_after", {31'd0, in_ready3}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
